pc_unit: RTL
============

# pc_unit

Program-counter stage that sits directly upstream of the instruction decoder. It holds the 10-bit program counter that addresses instruction memory. Each cycle it consumes the decoder's control-flow outputs (`is_jump`, `jump_cond`, `call`, `ret`, `operand`) together with the ALU flags to select the next PC. It also owns the hardware return-address stack used by CALL/RET.

## Interface
Parameters:
- `DEPTH`, default 8: return-stack entries; power of two, 2..64.
- `AW`, default 10: PC/address width; matches the operand field.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `en`  in  1  advance enable; when low, PC, stack and error flags hold.
- `is_jump`  in  1  current instruction is a jump/call/ret.
- `jump_cond`  in  `jump_t`  jump type; JMP=2'b00, JZ=2'b01, JNZ=2'b10, JC=2'b11.
- `call`  in  1  current instruction is CALL.
- `ret`  in  1  current instruction is RET.
- `target`  in  AW  jump/call destination; decoder `operand`.
- `zero`  in  1  accumulator-zero flag, registered in the datapath.
- `carry`  in  1  carry flag, registered in the datapath.
- `pc`  out  AW  current instruction address to instruction memory.
- `sp`  out  $clog2(DEPTH)+1  number of valid stack entries.
- `stack_ovf`  out  1  sticky: CALL issued with stack full.
- `stack_unf`  out  1  sticky: RET issued with stack empty.

## Operation
- `seq` = `pc + 1`, computed modulo 2^AW, so 1023 wraps to 0.
- `take` is 1 when `is_jump` and any of the following holds:
  - `jump_cond` = JMP;
  - JZ and `zero`;
  - JNZ and not `zero`;
  - JC and `carry`.
- Next-PC priority:
  1. RET with stack non-empty: next PC = top-of-stack, then pop.
  2. RET with stack empty: next PC = `seq`, `stack_unf` set, `sp` stays 0.
  3. CALL: next PC = `target`. If not full, push `seq` and increment `sp`. If full, discard the push, set `stack_ovf`, and leave `sp` unchanged. The jump is still taken.
  4. `take`: next PC = `target`.
  5. Otherwise: next PC = `seq`.
- CALL and RET asserted together is illegal; the block resolves it by letting RET win and ignoring CALL.
- `call` or `ret` without `is_jump`: the signals are acted on anyway. `is_jump` only gates conditional/plain jumps.
- Stack is LIFO over the `DEPTH` registers, indexed by `sp`. Top-of-stack = entry `sp-1`.
- `stack_ovf` / `stack_unf` stay set until `rst`. They do not halt the PC.

## Timing
- Reset values: `pc`=0, `sp`=0, `stack_ovf`=0, `stack_unf`=0. Stack contents are don't-care.
- `pc` is a register. Next-PC logic is combinational from the inputs and the current `pc`/stack, so a jump takes effect on the clock edge that ends the instruction cycle: zero bubble, one instruction per cycle.
- Flags `zero`/`carry` are sampled in the same cycle as the jump instruction. Their values come from the previous ALU instruction.
- `en`=0: no state changes, including stack pushes/pops and error flags.
- `rst` dominates `en` and all control inputs. Reset mid-call-sequence empties the stack in one cycle.
- Push and pop are single-cycle. RET immediately after CALL returns to the CALL address + 1.

## Structure
- `jump_t` (2-bit enum, values above) lives in the shared enums package alongside `data_src_t`. `pc_unit` imports it.
- Sub-module `return_stack`, parameterised by `DEPTH` and `AW`:
  - ports: `clk`, `rst`, `push`, `pop`, `din`, `dout`, `count`, `full`, `empty`;
  - owns the storage and the counter.
- `pc_unit` keeps the PC register, next-PC mux, condition evaluation and the sticky error flags.

## Test plan
- Reset then 5 cycles of no-op with `en`=1 -> `pc` = 0,1,2,3,4,5. Hold `en`=0 for 2 cycles -> `pc` holds at 5.
- PC=1023 with no jump -> next `pc`=0. JMP with `target`=10'h155 -> next `pc`=10'h155.
- JZ to 0x040 with `zero`=0 -> `pc`+1. Same with `zero`=1 -> 0x040. JNZ and JC are checked both ways likewise.
- CALL at pc=0x010 to 0x200, CALL at 0x200 to 0x300, then RET, RET:
  - `pc` sequence: 0x200, 0x300, 0x201, 0x011;
  - `sp` sequence: 1, 2, 1, 0.
- DEPTH+1 nested CALLs -> `stack_ovf`=1 on the last, `sp`=DEPTH, and the last target is still taken. Then RET with `sp`=0 -> `stack_unf`=1 and `pc` = `pc`+1. Then `rst` -> both flags are cleared.
- `rst` asserted with `sp`=3 -> next cycle `pc`=0 and `sp`=0.

Source files
------------

// File: rtl/pc_unit_pkg.sv
// rtl/pc_unit_pkg.sv - shared control enums for the fetch/decode front end
package pc_unit_pkg;

    typedef enum logic [1:0] {
        JMP = 2'b00,
        JZ  = 2'b01,
        JNZ = 2'b10,
        JC  = 2'b11
    } jump_t;

    typedef enum logic [1:0] {
        SRC_ALU  = 2'b00,
        SRC_MEM  = 2'b01,
        SRC_IMM  = 2'b10,
        SRC_PORT = 2'b11
    } data_src_t;

endpackage

// File: rtl/return_stack.sv
// rtl/return_stack.sv - LIFO of return addresses with occupancy counter
module return_stack #(
    parameter int DEPTH = 8,
    parameter int AW    = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [AW-1:0]            din,
    output logic [AW-1:0]            dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0] mem [DEPTH];
    logic [PW-1:0] top_idx;
    logic          do_push;
    logic          do_pop;

    assign top_idx = PW'(count - 1'b1);
    assign dout    = mem[top_idx];
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    // pop wins if both are requested; overflow/underflow requests are dropped
    assign do_pop  = pop && !empty;
    assign do_push = push && !full && !do_pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (do_pop) begin
            count <= count - 1'b1;
        end else if (do_push) begin
            count <= count + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && do_push) begin
            mem[count[PW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - program counter, next-PC selection and return-stack control
module pc_unit
    import pc_unit_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     is_jump,
    input  jump_t                    jump_cond,
    input  logic                     call,
    input  logic                     ret,
    input  logic [AW-1:0]            target,
    input  logic                     zero,
    input  logic                     carry,
    output logic [AW-1:0]            pc,
    output logic [$clog2(DEPTH):0]   sp,
    output logic                     stack_ovf,
    output logic                     stack_unf
);

    logic [AW-1:0] seq;
    logic [AW-1:0] next_pc;
    logic [AW-1:0] tos;
    logic          cond_ok;
    logic          take;
    logic          push_req;
    logic          pop_req;
    logic          set_ovf;
    logic          set_unf;
    logic          st_full;
    logic          st_empty;

    assign seq = pc + 1'b1;

    always_comb begin
        cond_ok = 1'b0;
        case (jump_cond)
            JMP:     cond_ok = 1'b1;
            JZ:      cond_ok = zero;
            JNZ:     cond_ok = !zero;
            JC:      cond_ok = carry;
            default: cond_ok = 1'b0;
        endcase
        take = is_jump && cond_ok;
    end

    // RET outranks CALL, which outranks plain/conditional jumps
    always_comb begin
        next_pc  = seq;
        push_req = 1'b0;
        pop_req  = 1'b0;
        set_ovf  = 1'b0;
        set_unf  = 1'b0;
        if (ret) begin
            if (!st_empty) begin
                next_pc = tos;
                pop_req = 1'b1;
            end else begin
                set_unf = 1'b1;
            end
        end else if (call) begin
            next_pc = target;
            if (!st_full) begin
                push_req = 1'b1;
            end else begin
                set_ovf = 1'b1;
            end
        end else if (take) begin
            next_pc = target;
        end
    end

    return_stack #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_return_stack (
        .clk   (clk),
        .rst   (rst),
        .push  (en && push_req),
        .pop   (en && pop_req),
        .din   (seq),
        .dout  (tos),
        .count (sp),
        .full  (st_full),
        .empty (st_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            pc        <= '0;
            stack_ovf <= 1'b0;
            stack_unf <= 1'b0;
        end else if (en) begin
            pc        <= next_pc;
            stack_ovf <= stack_ovf || set_ovf;
            stack_unf <= stack_unf || set_unf;
        end
    end

endmodule
